intra_mode_decider: RTL and testbench
=====================================

INTRA_MODE_DECIDER -- requirements
Module: intra_mode_decider

Interface
REQ-001 Parameter NUM_MODES, default 8: number of candidate prediction modes evaluated in parallel, range 2..16.
REQ-002 Parameter BLK_PIXELS, default 16: residual beats per block (16 = 4x4 luma, 64 = 8x8 chroma, 256 = 16x16 luma), range 2..256.
REQ-003 Parameter SAMPLE_W, default 9: width of one signed residual sample.
REQ-004 Parameter SAD_W, default 16: width of each SAD accumulator and of best_sad.
REQ-005 clk  in  1  sole clock; all state updates on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  global advance; when low, all state holds and res_ready is 0.
REQ-008 res_valid  in  1  residual beat valid.
REQ-009 res_ready  out  1  beat accepted when res_valid and res_ready are both high on a clk edge.
REQ-010 res_data  in  NUM_MODES*SAMPLE_W  one signed residual per mode for the same pixel; mode m occupies bits [m*SAMPLE_W +: SAMPLE_W].
REQ-011 res_last  in  1  producer marks the final beat of a block.
REQ-012 out_valid  out  1  decision available.
REQ-013 out_ready  in  1  consumer accepts the decision.
REQ-014 best_mode  out  4  index of the winning mode.
REQ-015 best_sad  out  SAD_W  SAD of the winning mode.
REQ-016 last_err  out  1  one-cycle pulse on a res_last / beat-count mismatch.

Function
REQ-017 The FSM SHALL have three states: ACCUM, SCAN and OUT; it SHALL leave reset in ACCUM with all accumulators at 0 and beat count at 0.
REQ-018 In ACCUM, res_ready SHALL equal enable; each accepted beat SHALL add |res_m| to accumulator m for every m and SHALL increment the beat count.
REQ-019 The absolute value of the most negative sample, -2^(SAMPLE_W-1), SHALL be 2^(SAMPLE_W-1); each accumulator SHALL saturate at 2^SAD_W-1 and never wrap.
REQ-020 The block SHALL end on acceptance of beat number BLK_PIXELS, independent of res_last; the FSM SHALL then move to SCAN on the next edge.
REQ-021 last_err SHALL pulse when res_last is high on an accepted beat other than beat BLK_PIXELS, or is low on beat BLK_PIXELS; the pulse SHALL not alter accumulation.
REQ-022 SCAN SHALL examine one mode per cycle in index order 0..NUM_MODES-1, taking NUM_MODES cycles; a candidate SHALL replace the current best only when its SAD is strictly smaller, so ties resolve to the lowest index.
REQ-023 After SCAN, the FSM SHALL enter OUT and hold out_valid high with best_mode and best_sad stable until out_ready is high; if the final beat is accepted on edge t, out_valid SHALL rise after edge t+NUM_MODES+1.
REQ-024 On the edge where out_valid and out_ready are both high, the FSM SHALL return to ACCUM with accumulators and beat count cleared, so the next block's first beat is accepted no earlier than the following cycle.
REQ-025 res_ready SHALL be 0 in SCAN and OUT; out_valid SHALL be 0 in ACCUM and SCAN.
REQ-026 When enable is low, FSM, counters, accumulators and outputs SHALL hold; out_valid stays asserted if in OUT, but no handshake completes.

Reset
REQ-027 Reset SHALL return the FSM to ACCUM and SHALL clear all accumulators, beat count and best registers; out_valid, best_mode, best_sad and last_err SHALL be 0; res_ready SHALL be 0 in the reset cycle.
REQ-028 Reset asserted mid-block or in SCAN/OUT SHALL discard the partial block and any pending decision with no output.

Configuration
REQ-029 With macro INTRA_MODE_MASK_EN defined, the block SHALL have an extra input mode_mask (NUM_MODES bits), sampled on the first accepted beat of each block; SCAN SHALL skip modes whose mask bit is 0.
REQ-030 With INTRA_MODE_MASK_EN defined and an all-zero sampled mask, the decision SHALL be best_mode=0 and best_sad=2^SAD_W-1.
REQ-031 Without INTRA_MODE_MASK_EN, the mode_mask port SHALL not exist and all modes SHALL be eligible.

Verification (NUM_MODES=4, BLK_PIXELS=16, SAMPLE_W=9, SAD_W=16)
REQ-032 16 beats of residuals (m0=5, m1=-3, m2=4, m3=-7), res_last on beat 16 -> best_mode=1, best_sad=48, out_valid 5 cycles after the last beat edge, last_err never high.
REQ-033 All modes equal at residual 2 -> best_mode=0, best_sad=32 (tie rule).
REQ-034 Mode 2 residual -256 for all beats, others 0 except mode 0 = 1 -> mode-2 SAD=4096 unsaturated; SAD_W=8 rerun -> mode-2 SAD=255, best_mode=1 (SAD 0).
REQ-035 res_last on beat 7 -> last_err pulses once, block still ends at beat 16 with correct SADs; out_ready held low 10 cycles -> outputs stable, res_ready 0 throughout.
REQ-036 reset asserted after beat 9 -> no out_valid; next full block yields a result uncontaminated by the first 9 beats.
REQ-037 INTRA_MODE_MASK_EN with mask=4'b1100 and the REQ-032 data -> best_mode=2, best_sad=64; mask=0 -> best_mode=0, best_sad=65535.

Source files
------------

// File: rtl/intra_mode_decider.sv
// intra_mode_decider: accumulates per-mode SAD over one residual block, then
// scans the modes one per cycle and presents the lowest-SAD mode (lowest
// index wins ties) until the consumer takes it.
// Optional feature: define INTRA_MODE_MASK_EN to add the mode_mask input,
// sampled on the first beat of each block; masked-off modes are skipped.
module intra_mode_decider #(
    parameter int NUM_MODES  = 8,
    parameter int BLK_PIXELS = 16,
    parameter int SAMPLE_W   = 9,
    parameter int SAD_W      = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          res_valid,
    output logic                          res_ready,
    input  logic [NUM_MODES*SAMPLE_W-1:0] res_data,
    input  logic                          res_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    best_mode,
    output logic [SAD_W-1:0]              best_sad,
    output logic                          last_err
`ifdef INTRA_MODE_MASK_EN
    ,
    input  logic [NUM_MODES-1:0]          mode_mask
`endif
);
    localparam int IDX_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int CNT_W = $clog2(BLK_PIXELS + 1);
    localparam int SUM_W = ((SAD_W > SAMPLE_W) ? SAD_W : SAMPLE_W) + 1;
    localparam logic [SAD_W-1:0] SAD_MAX = '1;

    typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [NUM_MODES-1:0][SAD_W-1:0] acc_q, acc_d, acc_add;
    logic [IDX_W-1:0]                scan_q, scan_d;
    logic [3:0]                      best_mode_q, best_mode_d;
    logic [SAD_W-1:0]                best_sad_q, best_sad_d;
    logic                            found_q, found_d;
    logic                            last_err_q, last_err_d;
    logic [NUM_MODES-1:0]            elig;
    logic                            blk_full, beat_is_last;

`ifdef INTRA_MODE_MASK_EN
    logic [NUM_MODES-1:0]            mask_q, mask_d;
    assign elig = mask_q;
`else
    assign elig = '1;
`endif

    // Block is full once BLK_PIXELS beats are in; res_last is only checked.
    assign blk_full     = (cnt_q == CNT_W'(BLK_PIXELS));
    assign beat_is_last = (cnt_q == CNT_W'(BLK_PIXELS - 1));

    // Per-mode |residual| and saturating accumulate. The magnitude is kept
    // unsigned so the most negative sample maps to 2^(SAMPLE_W-1).
    for (genvar m = 0; m < NUM_MODES; m++) begin : g_mode
        logic [SAMPLE_W-1:0] smp, mag;
        logic [SUM_W-1:0]    sum;
        assign smp        = res_data[m*SAMPLE_W +: SAMPLE_W];
        assign mag        = smp[SAMPLE_W-1] ? (~smp + SAMPLE_W'(1)) : smp;
        assign sum        = SUM_W'(acc_q[m]) + SUM_W'(mag);
        assign acc_add[m] = (sum > SUM_W'(SAD_MAX)) ? SAD_MAX : sum[SAD_W-1:0];
    end

    assign out_valid = (state_q == OUT);
    assign best_mode = best_mode_q;
    assign best_sad  = best_sad_q;
    assign last_err  = last_err_q;

    // State and datapath registers; synchronous reset drops any block in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ACCUM;
            cnt_q       <= '0;
            acc_q       <= '0;
            scan_q      <= '0;
            best_mode_q <= '0;
            best_sad_q  <= '0;
            found_q     <= 1'b0;
            last_err_q  <= 1'b0;
`ifdef INTRA_MODE_MASK_EN
            mask_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            scan_q      <= scan_d;
            best_mode_q <= best_mode_d;
            best_sad_q  <= best_sad_d;
            found_q     <= found_d;
            last_err_q  <= last_err_d;
`ifdef INTRA_MODE_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    // Next-state logic: accumulate, scan one mode per cycle, hold the result.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        scan_d      = scan_q;
        best_mode_d = best_mode_q;
        best_sad_d  = best_sad_q;
        found_d     = found_q;
        last_err_d  = last_err_q;
`ifdef INTRA_MODE_MASK_EN
        mask_d      = mask_q;
`endif
        res_ready   = 1'b0;
        if (enable) begin
            last_err_d = 1'b0;
            case (state_q)
                ACCUM: begin
                    // The cycle after the final beat stalls input and seeds the scan.
                    res_ready = !reset && !blk_full;
                    if (blk_full) begin
                        state_d     = SCAN;
                        scan_d      = '0;
                        best_mode_d = '0;
                        best_sad_d  = SAD_MAX;
                        found_d     = 1'b0;
                    end else if (res_valid) begin
                        acc_d      = acc_add;
                        cnt_d      = cnt_q + CNT_W'(1);
                        last_err_d = (res_last != beat_is_last);
`ifdef INTRA_MODE_MASK_EN
                        if (cnt_q == '0) mask_d = mode_mask;
`endif
                    end
                end
                SCAN: begin
                    // The first eligible mode always seeds; later ones need strictly less.
                    if (elig[scan_q] && (!found_q || acc_q[scan_q] < best_sad_q)) begin
                        found_d     = 1'b1;
                        best_mode_d = 4'(scan_q);
                        best_sad_d  = acc_q[scan_q];
                    end
                    if (scan_q == IDX_W'(NUM_MODES - 1)) state_d = OUT;
                    else                                 scan_d  = scan_q + IDX_W'(1);
                end
                OUT: begin
                    if (out_ready) begin
                        state_d = ACCUM;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ACCUM;
            endcase
        end
    end
endmodule

// File: tb/tb_intra_mode_decider.sv
// Bench for intra_mode_decider: table vectors, hand sequences for reset and
// handshake corners, and randomized blocks against a behavioural model.
// A second instance with SAD_W=8 shares the inputs to expose saturation.
module tb_intra_mode_decider;
    localparam int NM = 4;
    localparam int BP = 16;
    localparam int SW = 9;

    logic          clk = 1'b0;
    logic          reset, enable, res_valid, res_last, out_ready;
    logic [NM*SW-1:0] res_data;
    logic          res_ready, out_valid, last_err;
    logic          res_ready8, out_valid8, last_err8;
    logic [3:0]    best_mode, best_mode8;
    logic [15:0]   best_sad;
    logic [7:0]    best_sad8;
`ifdef INTRA_MODE_MASK_EN
    logic [NM-1:0] mode_mask;
`endif

    always #5 clk = ~clk;

    intra_mode_decider #(.NUM_MODES(NM), .BLK_PIXELS(BP), .SAMPLE_W(SW), .SAD_W(16)) dut (
        .clk(clk), .reset(reset), .enable(enable), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_last(res_last),
        .out_valid(out_valid), .out_ready(out_ready), .best_mode(best_mode),
        .best_sad(best_sad), .last_err(last_err)
`ifdef INTRA_MODE_MASK_EN
        , .mode_mask(mode_mask)
`endif
    );

    intra_mode_decider #(.NUM_MODES(NM), .BLK_PIXELS(BP), .SAMPLE_W(SW), .SAD_W(8)) dut8 (
        .clk(clk), .reset(reset), .enable(enable), .res_valid(res_valid),
        .res_ready(res_ready8), .res_data(res_data), .res_last(res_last),
        .out_valid(out_valid8), .out_ready(out_ready), .best_mode(best_mode8),
        .best_sad(best_sad8), .last_err(last_err8)
`ifdef INTRA_MODE_MASK_EN
        , .mode_mask(mode_mask)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int beat_r[BP][NM];
    logic [NM-1:0] cur_mask = '1;

    typedef struct {
        int r0, r1, r2, r3;
        logic [BP-1:0] lm;
        int hold;
        int em, es, em8, es8;
    } vec_t;
    vec_t tbl[6];

    task automatic check(input string nm, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: per-mode sum of magnitudes clamped to the SAD range, then
    // the lowest value among enabled modes, earliest index on ties.
    function automatic void model(input int sadw, input logic [NM-1:0] msk,
                                  output int bm, output int bs);
        int mx, s;
        bit found;
        mx = (1 << sadw) - 1;
        bm = 0; bs = mx; found = 0;
        for (int m = 0; m < NM; m++) begin
            if (msk[m]) begin
                s = 0;
                for (int b = 0; b < BP; b++) s += (beat_r[b][m] < 0) ? -beat_r[b][m] : beat_r[b][m];
                if (s > mx) s = mx;
                if (!found || s < bs) begin found = 1; bm = m; bs = s; end
            end
        end
    endfunction

    task automatic drive_beat(input int i, input bit lst);
        for (int m = 0; m < NM; m++) res_data[m*SW +: SW] = SW'(beat_r[i][m]);
        res_last = lst;
    endtask

    task automatic fill_const(input int a, input int b, input int c, input int d);
        for (int i = 0; i < BP; i++) begin
            beat_r[i][0] = a; beat_r[i][1] = b; beat_r[i][2] = c; beat_r[i][3] = d;
        end
    endtask

    // Sends one block, measures decision latency, checks results, holds off
    // out_ready, tries a handshake with enable low, then completes it.
    task automatic run_block(input string nm, input logic [BP-1:0] lm, input int hold,
                             input bit rnd_en, input bit use_exp,
                             input int em, input int es, input int em8, input int es8);
        int i, errs, exp_errs, cyc, guard, xm, xs, xm8, xs8;
        bit acc, bad_ready, stable_ok;
        logic [3:0]  m0;
        logic [15:0] s0;
        i = 0; errs = 0; guard = 0; bad_ready = 0; stable_ok = 1; exp_errs = 0;
        for (int k = 0; k < BP; k++) if (lm[k] != (k == BP - 1)) exp_errs++;
        if (use_exp) begin
            xm = em; xs = es; xm8 = em8; xs8 = es8;
        end else begin
            model(16, cur_mask, xm, xs);
            model(8, cur_mask, xm8, xs8);
        end
        out_ready = 1'b0;
        while (i < BP && guard < 400) begin
            guard++;
            enable    = rnd_en ? ($urandom_range(3) != 0) : 1'b1;
            res_valid = 1'b1;
            drive_beat(i, lm[i]);
`ifdef INTRA_MODE_MASK_EN
            mode_mask = (i == 0) ? cur_mask : ~cur_mask;
`endif
            #1;
            acc = res_ready;
            if (acc != enable) bad_ready = 1;
            @(posedge clk); #1;
            if (acc) begin errs += int'(last_err); i++; end
        end
        check({nm, "_beats_taken"}, i, BP);
        res_valid = 1'b0; res_last = 1'b0; enable = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (res_ready) bad_ready = 1;
            errs += int'(last_err);
        end
        check({nm, "_latency"}, cyc, NM + 1);
        check({nm, "_best_mode"}, int'(best_mode), xm);
        check({nm, "_best_sad"}, int'(best_sad), xs);
        check({nm, "_best_mode_sad8"}, int'(best_mode8), xm8);
        check({nm, "_best_sad_sad8"}, int'(best_sad8), xs8);
        m0 = best_mode; s0 = best_sad;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || best_mode !== m0 || best_sad !== s0 || res_ready) stable_ok = 0;
        end
        enable = 1'b0; out_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (!out_valid || best_mode !== m0 || best_sad !== s0 || res_ready) stable_ok = 0;
        end
        check({nm, "_out_stable"}, int'(stable_ok), 1);
        enable = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_handshake_done"}, int'(out_valid), 0);
        check({nm, "_ready_again"}, int'(res_ready), 1);
        check({nm, "_ready_rule"}, int'(bad_ready), 0);
        check({nm, "_last_err_pulses"}, errs, exp_errs);
    endtask

    initial begin
        tbl[0] = '{5, -3, 4, -7, 16'h8000, 0, 1, 48, 1, 48};
        tbl[1] = '{2, 2, 2, 2, 16'h8000, 0, 0, 32, 0, 32};
        tbl[2] = '{1, 0, -256, 0, 16'h8000, 0, 1, 0, 1, 0};
        tbl[3] = '{-256, -256, -256, -256, 16'h8000, 0, 0, 4096, 0, 255};
        tbl[4] = '{5, -3, 4, -7, 16'h8040, 10, 1, 48, 1, 48};
        tbl[5] = '{-3, 7, -3, 9, 16'h0000, 2, 0, 48, 0, 48};

        reset = 1'b1; enable = 1'b1; res_valid = 1'b0; res_last = 1'b0;
        out_ready = 1'b0; res_data = '0;
`ifdef INTRA_MODE_MASK_EN
        mode_mask = '1;
`endif
        #1;
        check("reset_cycle_res_ready", int'(res_ready), 0);
        @(posedge clk); #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_best_mode", int'(best_mode), 0);
        check("reset_best_sad", int'(best_sad), 0);
        check("reset_last_err", int'(last_err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check("post_reset_res_ready", int'(res_ready), 1);

        // Table vectors
        foreach (tbl[k]) begin
            fill_const(tbl[k].r0, tbl[k].r1, tbl[k].r2, tbl[k].r3);
            run_block($sformatf("vec%0d", k), tbl[k].lm, tbl[k].hold, 1'b0, 1'b1,
                      tbl[k].em, tbl[k].es, tbl[k].em8, tbl[k].es8);
        end

        // Reset after 9 beats: partial block must vanish without a decision.
        fill_const(0, 50, 0, 0);
        for (int i = 0; i < 9; i++) begin
            res_valid = 1'b1;
            drive_beat(i, 1'b0);
            @(posedge clk); #1;
        end
        res_valid = 1'b0;
        reset = 1'b1;
        #1;
        check("midblk_reset_res_ready", int'(res_ready), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        check("midblk_reset_best_sad", int'(best_sad), 0);
        begin
            bit seen;
            seen = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (out_valid) seen = 1;
            end
            check("midblk_reset_no_out", int'(seen), 0);
        end
        fill_const(5, -3, 4, -7);
        run_block("after_reset", 16'h8000, 0, 1'b0, 1'b1, 1, 48, 1, 48);

`ifdef INTRA_MODE_MASK_EN
        cur_mask = 4'b1100;
        run_block("mask_1100", 16'h8000, 0, 1'b0, 1'b1, 2, 64, 2, 64);
        cur_mask = 4'b0000;
        run_block("mask_0000", 16'h8000, 0, 1'b0, 1'b1, 0, 65535, 0, 255);
        cur_mask = '1;
`endif

        // Randomized blocks against the model, with enable bubbles on input.
        for (int t = 0; t < 20; t++) begin
            logic [BP-1:0] lm;
            for (int b = 0; b < BP; b++)
                for (int m = 0; m < NM; m++)
                    beat_r[b][m] = (t % 3 == 0) ? int'($urandom_range(511)) - 256
                                                : int'($urandom_range(40)) - 20;
            lm = 16'h8000;
            if ($urandom_range(3) == 0) lm = 16'($urandom);
`ifdef INTRA_MODE_MASK_EN
            cur_mask = 4'($urandom);
`endif
            run_block($sformatf("rnd%0d", t), lm, int'($urandom_range(3)), 1'b1, 1'b0, 0, 0, 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
